// File: rtl/feature_pkg.sv
// ============================================================================
// feature_pkg
// Shared types and helpers for the multi-channel CNN feature FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

package feature_pkg;

    localparam int FEAT_W = 8;

    typedef logic [FEAT_W-1:0] feature_t;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/feature_fwft_ram.sv
// ============================================================================
// feature_fwft_ram
// Simple dual-port register array: synchronous write, asynchronous read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module feature_fwft_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    // No reset on the array: contents are don't-care until written.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/feature_fwft_fifo.sv
// ============================================================================
// feature_fwft_fifo
// Multi-channel first-word-fall-through FIFO with occupancy and backpressure.
// Optional sticky overflow/underflow flags when FEATURE_FWFT_ERR_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module feature_fwft_fifo
    import feature_pkg::*;
#(
    parameter int DATA_W   = FEAT_W,
    parameter int CHANNELS = 1,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [CHANNELS*DATA_W-1:0]     in_feature,
    input  logic                           rd_en,
    output logic [CHANNELS*DATA_W-1:0]     out_feature,
    output logic                           empty,
    output logic                           full,
    output logic                           almost_full,
    output logic [clog2_cnt(DEPTH)-1:0]    count
`ifdef FEATURE_FWFT_ERR_EN
    ,
    output logic                           overflow,
    output logic                           underflow
`endif
);

    localparam int WORD_W = CHANNELS * DATA_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = clog2_cnt(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic [WORD_W-1:0] head_word;
    logic              wr_ok;
    logic              rd_ok;
    logic              ram_we;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign rd_ok  = rd_en && !empty;
    assign wr_ok  = wr_en && (!full || rd_ok);
    assign ram_we = wr_ok && !rst;

    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + CNT_W'(1);
        end else if (!wr_ok && rd_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_next;
            empty       <= (count_next == '0);
            full        <= (count_next == DEPTH_CNT);
            almost_full <= (count_next >= AFULL_CNT);
        end
    end

`ifdef FEATURE_FWFT_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !rd_ok) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    feature_fwft_ram #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (in_feature),
        .rd_addr (rd_ptr),
        .rd_data (head_word)
    );

    // Stale array contents must never leak out while the FIFO is empty.
    assign out_feature = empty ? '0 : head_word;

endmodule

`default_nettype wire

// File: doc/feature_fwft_fifo.md
# feature_fwft_fifo

Parametrised, multi-channel first-word-fall-through FIFO for CNN feature streams. It sits between the feature source (pixel/line reader) and the convolution datapath. Each entry holds CHANNELS feature lanes that are written and read together. It adds full/almost-full backpressure, an occupancy count and optional error flags, which the single-lane 8-bit feature FWFT lacks.

## Interface
- DATA_W, 8, bits per feature lane
- CHANNELS, 1, lanes per entry (1..16)
- DEPTH, 16, entries; power of two, >= 4
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  push request
- in_feature  in  CHANNELS*DATA_W  push data; lane k at bits [k*DATA_W +: DATA_W]
- rd_en  in  1  pop request; head is already presented on out_feature
- out_feature  out  CHANNELS*DATA_W  head entry; all zeros when empty
- empty  out  1  no entries
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AFULL_TH
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow, underflow  out  1 each  sticky error flags; present only with FEATURE_FWFT_ERR_EN

## Operation
- Storage is DEPTH x (CHANNELS*DATA_W). Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no extra logic.
- Push accepted (wr_ok) = wr_en && (!full || rd_ok). A push while full is accepted only if a pop occurs in the same cycle.
- Pop accepted (rd_ok) = rd_en && !empty. A pop while empty is ignored.
- count_next = count + wr_ok - rd_ok. Saturation cannot occur given the acceptance rules.
- empty = (count == 0), full = (count == DEPTH), almost_full = (count >= AFULL_TH). All three are registered: they are derived from count_next and updated on the same edge as count.
- out_feature = mem[rd_ptr] when !empty, else 0. This is a combinational read of the registered head, so the head is visible before rd_en (FWFT).
- Simultaneous push+pop with count == 0: the pop is ignored, the push is accepted, and count becomes 1.
- Simultaneous push+pop with 0 < count < DEPTH: both are accepted and count is unchanged.
- Lanes are never reordered or mixed; an entry is atomic.

## Timing
- Reset (rst=1 at a rising edge): count=0, pointers=0, empty=1, full=0, almost_full=0, out_feature=0, error flags=0. Memory contents are not cleared.
- A reset asserted mid-stream discards all entries on that edge. Inputs are ignored while rst=1.
- Write-to-read latency: a push at edge N makes empty=0 and the data visible on out_feature after edge N. The entry can be popped at edge N+1.
- A pop at edge N advances the head after edge N. The next entry (or 0 if now empty) is visible in the same cycle.
- Flag latency is 0 cycles relative to count; all flags change on the same edge.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- FEATURE_FWFT_ERR_EN defined:
  - overflow is set on wr_en && full && !rd_ok.
  - underflow is set on rd_en && empty.
  - Both flags are sticky until rst.
- FEATURE_FWFT_ERR_EN undefined: the ports and logic are absent. The dropped push or pop is silently ignored, with the same FIFO behaviour.

## Structure
- Shared package feature_pkg holds:
  - localparam FEAT_W = 8
  - typedef logic [FEAT_W-1:0] feature_t
  - function clog2_cnt(depth) for count width
- Sub-module feature_fwft_ram: simple dual-port register array with synchronous write and asynchronous read. The top level holds pointers, count and flags.

## Test plan
All scenarios use DATA_W=8, CHANNELS=3, DEPTH=16 and AFULL_TH=14 unless noted.
1. Reset, then push {03,02,01} once, no rd_en -> after 1 edge empty=0, count=1, out_feature=0x030201; after a pop, empty=1 and out_feature=0.
2. Push an incrementing pattern 16 times -> almost_full rises on the 14th push and full on the 16th. A 17th push with rd_en=0 leaves count=16 and the head unchanged; overflow=1 if FEATURE_FWFT_ERR_EN is defined.
3. When full, assert wr_en and rd_en together for 40 cycles -> count stays 16 and the popped sequence is contiguous across pointer wrap.
4. When empty, assert wr_en and rd_en together -> the push is accepted, count=1 and out_feature holds the pushed word. With FEATURE_FWFT_ERR_EN defined, underflow=1.
5. Push 8 entries, pop 3, assert rst for 1 cycle -> count=0, empty=1, flags=0, out_feature=0. The next push's data appears at the head.
6. Random wr_en/rd_en at 50% for 4096 cycles against a queue model -> every popped word matches the model and count matches the model every cycle.
